pattern_seq_checker: RTL and testbench
======================================

// Module: pattern_seq_checker
// PURPOSE
// - Receive end of the 3-bit header/fill pattern stream (header 101, 111, then fill 000 repeated).
// - Hunts for the header, then counts fill symbols to declare lock.
// - Flags and counts any symbol that breaks the pattern while locked.
// - Sits on the consumer side of the pattern link; status and counters go to the debug/CSR logic.
// PARAMETERS
// - W          3       symbol width
// - SYM_A      3'b101  first header symbol
// - SYM_B      3'b111  second header symbol
// - SYM_FILL   3'b000  fill symbol
// - LOCK_FILL  4       consecutive fills after the header needed for lock (>=1; elaboration error if 0)
// - ERR_CNT_W  8       err_count width
// - FILL_CNT_W 16      fill_count width
// PORTS
// - clk         in   1           clock; all logic on rising edge
// - rst         in   1           synchronous, active-high reset
// - din_valid   in   1           din is a symbol this cycle
// - din         in   W           received symbol
// - clr_err     in   1           clear err_count
// - locked      out  1           pattern lock status
// - frame_start out  1           1-cycle pulse: header (SYM_A,SYM_B) accepted
// - err_pulse   out  1           1-cycle pulse: pattern violation while locked
// - err_count   out  ERR_CNT_W   saturating violation count
// - fill_count  out  FILL_CNT_W  saturating fills since the last header
// BEHAVIOUR
// - Outputs are registered and reflect an accepted symbol one cycle after acceptance.
// - A symbol is accepted only when din_valid=1. With din_valid=0: state and counts hold,
//   pulses are 0, and din is ignored.
// - Reset (rst=1): state=HUNT, all outputs 0, internal fill counter 0. Reset dominates every
//   other input, including mid-frame and while locked.
// - FSM states (shared enum): HUNT, GOT_A, FILL_CHK, LOCKED.
// - HUNT
//   - din==SYM_A -> GOT_A.
//   - Anything else -> stay in HUNT. No errors are ever counted in HUNT.
// - GOT_A
//   - din==SYM_B -> FILL_CHK. Pulse frame_start. Clear fill_count to 0.
//   - din==SYM_A -> stay in GOT_A.
//   - Otherwise -> HUNT.
// - FILL_CHK
//   - din==SYM_FILL -> fill_count+1.
//   - On the LOCK_FILL-th fill: -> LOCKED, locked=1 in the next cycle.
//   - din==SYM_A -> GOT_A (restart). Otherwise -> HUNT. Neither case counts an error.
// - LOCKED
//   - din==SYM_FILL -> stay; fill_count+1, saturating at all-ones.
//   - din==SYM_A -> GOT_A, locked=0. This is a legal re-header: no error.
//   - Any other symbol -> HUNT, locked=0, err_pulse=1, err_count+1 (saturating).
// - err_count
//   - Saturates at 2^ERR_CNT_W-1.
//   - clr_err alone -> 0 in the next cycle.
//   - clr_err in the same cycle as an error -> 1 (the error is never lost).
// - fill_count holds its value in HUNT/GOT_A and is cleared only on header acceptance or reset.
// - SYM_A, SYM_B and SYM_FILL must be distinct (checked by assertion).
// STRUCTURE
// - Package pattern_pkg holds:
//   - the state enum {HUNT, GOT_A, FILL_CHK, LOCKED};
//   - the localparams SYM_A, SYM_B, SYM_FILL;
//   - the symbol width.
//   The pattern generator uses the same constants.
// - One sub-module: sat_counter.
//   - Parameters: width. Inputs: inc, clr, with inc winning after clr.
//   - Saturating; instantiated twice (err_count, fill_count).
// - The FSM and the lock comparison against LOCK_FILL live in this module.
// TESTING
// 1. Reset, then 101,111,000x4 (LOCK_FILL=4): frame_start=1 exactly one cycle after 111 is
//    accepted; locked=1 one cycle after the 4th 000; fill_count=4.
// 2. From lock, send 010: err_pulse=1 for one cycle, err_count=1, locked=0. Following 000s are
//    ignored (fill_count holds, no more errors).
// 3. Repeat test 1 with random din_valid=0 gaps carrying garbage din: identical outputs, only
//    time-shifted.
// 4. ERR_CNT_W=2, five lock/violate cycles: err_count stops at 3. clr_err together with an
//    error: err_count=1. clr_err alone: err_count=0.
// 5. rst=1 for one cycle during FILL_CHK after 2 fills: next cycle all outputs 0. Then
//    000x4 gives no lock; 101,111,000x4 locks.
// 6. Send 101,101,111 -> frame_start pulses. Then from lock send 101: locked drops with no
//    err_pulse; 111,000x4 re-locks.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared constants and state type for the 3-bit header/fill pattern link.
// The generator and the checker both import this package.
package pattern_pkg;

    localparam int unsigned SYM_W = 3;

    localparam logic [SYM_W-1:0] SYM_A    = 3'b101;
    localparam logic [SYM_W-1:0] SYM_B    = 3'b111;
    localparam logic [SYM_W-1:0] SYM_FILL = 3'b000;

    typedef enum logic [1:0] {
        HUNT,
        GOT_A,
        FILL_CHK,
        LOCKED
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; an increment in the clear cycle yields 1.
module sat_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_d;
    logic [Width-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end
        if (inc_i && (count_d != {Width{1'b1}})) begin
            count_d = count_d + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pattern_seq_checker.sv
// Receive-side checker: hunts for the header, declares lock after LOCK_FILL fills,
// and flags/counts pattern breaks while locked.
module pattern_seq_checker #(
    parameter int unsigned      W          = pattern_pkg::SYM_W,
    parameter logic [W-1:0]     SYM_A      = pattern_pkg::SYM_A,
    parameter logic [W-1:0]     SYM_B      = pattern_pkg::SYM_B,
    parameter logic [W-1:0]     SYM_FILL   = pattern_pkg::SYM_FILL,
    parameter int unsigned      LOCK_FILL  = 4,
    parameter int unsigned      ERR_CNT_W  = 8,
    parameter int unsigned      FILL_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  din_valid,
    input  logic [W-1:0]          din,
    input  logic                  clr_err,
    output logic                  locked,
    output logic                  frame_start,
    output logic                  err_pulse,
    output logic [ERR_CNT_W-1:0]  err_count,
    output logic [FILL_CNT_W-1:0] fill_count
);

    import pattern_pkg::*;

    localparam longint unsigned FillMax = (64'd1 << FILL_CNT_W) - 64'd1;
    localparam logic [FILL_CNT_W-1:0] LockLast = FILL_CNT_W'(LOCK_FILL - 1);

    if (LOCK_FILL == 0) begin : gen_bad_lock_fill
        $error("pattern_seq_checker: LOCK_FILL must be at least 1");
    end

    // Lock is judged on fill_count itself, so it must be able to reach LOCK_FILL.
    if (64'(LOCK_FILL) > FillMax) begin : gen_bad_fill_width
        $error("pattern_seq_checker: LOCK_FILL does not fit in FILL_CNT_W");
    end

    if ((SYM_A == SYM_B) || (SYM_A == SYM_FILL) || (SYM_B == SYM_FILL)) begin : gen_bad_syms
        $error("pattern_seq_checker: SYM_A, SYM_B and SYM_FILL must be distinct");
    end

    state_e state_d, state_q;
    logic   locked_d, locked_q;
    logic   frame_start_d, frame_start_q;
    logic   err_pulse_d, err_pulse_q;
    logic   fill_inc, fill_clr;

    always_comb begin
        state_d       = state_q;
        frame_start_d = 1'b0;
        err_pulse_d   = 1'b0;
        fill_inc      = 1'b0;
        fill_clr      = 1'b0;

        if (din_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (din == SYM_A) begin
                        state_d = GOT_A;
                    end
                end
                GOT_A: begin
                    if (din == SYM_B) begin
                        state_d       = FILL_CHK;
                        frame_start_d = 1'b1;
                        fill_clr      = 1'b1;
                    end else if (din != SYM_A) begin
                        state_d = HUNT;
                    end
                end
                FILL_CHK: begin
                    if (din == SYM_FILL) begin
                        fill_inc = 1'b1;
                        if (fill_count == LockLast) begin
                            state_d = LOCKED;
                        end
                    end else if (din == SYM_A) begin
                        state_d = GOT_A;
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    if (din == SYM_FILL) begin
                        fill_inc = 1'b1;
                    end else if (din == SYM_A) begin
                        // Legal re-header, not a violation.
                        state_d = GOT_A;
                    end else begin
                        state_d     = HUNT;
                        err_pulse_d = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HUNT;
            locked_q      <= 1'b0;
            frame_start_q <= 1'b0;
            err_pulse_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            locked_q      <= locked_d;
            frame_start_q <= frame_start_d;
            err_pulse_q   <= err_pulse_d;
        end
    end

    sat_counter #(
        .Width (ERR_CNT_W)
    ) u_err_cnt (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (clr_err),
        .inc_i   (err_pulse_d),
        .count_o (err_count)
    );

    sat_counter #(
        .Width (FILL_CNT_W)
    ) u_fill_cnt (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (fill_clr),
        .inc_i   (fill_inc),
        .count_o (fill_count)
    );

    assign locked      = locked_q;
    assign frame_start = frame_start_q;
    assign err_pulse   = err_pulse_q;

endmodule

// File: tb/tb_pattern_seq_checker.sv
// Randomized and directed bench for pattern_seq_checker against a symbol-history model.
module tb_pattern_seq_checker;

    localparam logic [2:0] A = 3'b101;
    localparam logic [2:0] B = 3'b111;
    localparam logic [2:0] F = 3'b000;
    localparam int LockN = 4;

    logic        clk = 1'b0;
    logic        rst, din_valid, clr_err;
    logic [2:0]  din;

    logic        locked, frame_start, err_pulse;
    logic [7:0]  err_count;
    logic [15:0] fill_count;
    logic        locked2, frame_start2, err_pulse2;
    logic [1:0]  err_count2;
    logic [2:0]  fill_count2;

    int total = 0;
    int bad   = 0;

    // Reference model: framing status derived from the symbol history rules.
    bit m_have_a, m_in_frame, m_lock, m_fs, m_ep;
    int m_fills, m_err8, m_err2;

    always #5 clk = ~clk;

    pattern_seq_checker #(
        .LOCK_FILL (LockN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din_valid   (din_valid),
        .din         (din),
        .clr_err     (clr_err),
        .locked      (locked),
        .frame_start (frame_start),
        .err_pulse   (err_pulse),
        .err_count   (err_count),
        .fill_count  (fill_count)
    );

    pattern_seq_checker #(
        .LOCK_FILL  (LockN),
        .ERR_CNT_W  (2),
        .FILL_CNT_W (3)
    ) dut_small (
        .clk         (clk),
        .rst         (rst),
        .din_valid   (din_valid),
        .din         (din),
        .clr_err     (clr_err),
        .locked      (locked2),
        .frame_start (frame_start2),
        .err_pulse   (err_pulse2),
        .err_count   (err_count2),
        .fill_count  (fill_count2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_update(input bit v, input logic [2:0] d, input bit c, input bit r);
        bit err;
        err  = 1'b0;
        m_fs = 1'b0;
        if (r) begin
            m_have_a = 0; m_in_frame = 0; m_lock = 0;
            m_fills = 0; m_err8 = 0; m_err2 = 0;
        end else begin
            if (v) begin
                if (m_lock) begin
                    if (d == F) begin
                        m_fills++;
                    end else begin
                        m_lock = 0; m_in_frame = 0;
                        m_have_a = (d == A);
                        err = (d != A);
                    end
                end else if (m_in_frame) begin
                    if (d == F) begin
                        m_fills++;
                        if (m_fills == LockN) m_lock = 1;
                    end else begin
                        m_in_frame = 0;
                        m_have_a = (d == A);
                    end
                end else begin
                    if (m_have_a && d == B) begin
                        m_in_frame = 1; m_fills = 0; m_fs = 1;
                    end
                    m_have_a = (d == A);
                end
            end
            if (c) begin
                m_err8 = 0; m_err2 = 0;
            end
            if (err) begin
                m_err8 = min_i(m_err8 + 1, 255);
                m_err2 = min_i(m_err2 + 1, 3);
            end
        end
        m_ep = err;
    endtask

    task automatic compare_all();
        check_eq("locked", 32'(locked), 32'(m_lock));
        check_eq("frame_start", 32'(frame_start), 32'(m_fs));
        check_eq("err_pulse", 32'(err_pulse), 32'(m_ep));
        check_eq("err_count", 32'(err_count), 32'(m_err8));
        check_eq("fill_count", 32'(fill_count), 32'(min_i(m_fills, 65535)));
        check_eq("small_locked", 32'(locked2), 32'(m_lock));
        check_eq("small_frame_start", 32'(frame_start2), 32'(m_fs));
        check_eq("small_err_pulse", 32'(err_pulse2), 32'(m_ep));
        check_eq("small_err_count", 32'(err_count2), 32'(m_err2));
        check_eq("small_fill_count", 32'(fill_count2), 32'(min_i(m_fills, 7)));
    endtask

    task automatic step(input bit v, input logic [2:0] d, input bit c, input bit r);
        din_valid = v; din = d; clr_err = c; rst = r;
        @(posedge clk);
        model_update(v, d, c, r);
        #1;
        compare_all();
    endtask

    task automatic send(input logic [2:0] d);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic send_gappy(input logic [2:0] d);
        int gaps;
        gaps = $urandom_range(0, 2);
        for (int i = 0; i < gaps; i++) step(1'b0, 3'($urandom), 1'b0, 1'b0);
        send(d);
    endtask

    task automatic lock_seq();
        send(A); send(B);
        for (int i = 0; i < LockN; i++) send(F);
    endtask

    initial begin
        logic [2:0] pick [6];
        pick[0] = A; pick[1] = B; pick[2] = F; pick[3] = F; pick[4] = F; pick[5] = 3'b010;

        step(1'b0, 3'd0, 1'b0, 1'b1);
        step(1'b0, 3'd0, 1'b0, 1'b1);
        check_eq("reset_err_count", 32'(err_count), 32'd0);

        // Lock, then violate and confirm trailing fills are ignored.
        lock_seq();
        check_eq("t1_locked", 32'(locked), 32'd1);
        check_eq("t1_fill_count", 32'(fill_count), 32'd4);
        send(3'b010);
        check_eq("t2_err_pulse", 32'(err_pulse), 32'd1);
        send(F); send(F);
        check_eq("t2_fill_hold", 32'(fill_count), 32'd4);

        // Same lock sequence with idle gaps carrying garbage.
        send_gappy(A); send_gappy(B);
        for (int i = 0; i < LockN; i++) send_gappy(F);
        check_eq("t3_locked", 32'(locked), 32'd1);

        // Saturate the 2-bit counter, then clear with and without a coincident error.
        send(3'b011);
        for (int k = 0; k < 4; k++) begin
            lock_seq();
            send(3'b110);
        end
        check_eq("t4_err_sat", 32'(err_count2), 32'd3);
        lock_seq();
        step(1'b1, 3'b010, 1'b1, 1'b0);
        check_eq("t4_clr_with_err", 32'(err_count2), 32'd1);
        step(1'b0, 3'd0, 1'b1, 1'b0);
        check_eq("t4_clr_alone", 32'(err_count), 32'd0);

        // Reset mid-fill.
        send(A); send(B); send(F); send(F);
        step(1'b1, F, 1'b0, 1'b1);
        for (int i = 0; i < LockN; i++) send(F);
        check_eq("t5_no_lock", 32'(locked), 32'd0);
        lock_seq();
        check_eq("t5_relock", 32'(locked), 32'd1);

        // Repeated A before B, then re-header from lock.
        send(A); send(A); send(B);
        check_eq("t6_frame_start", 32'(frame_start), 32'd1);
        for (int i = 0; i < LockN; i++) send(F);
        send(A);
        check_eq("t6_no_err", 32'(err_pulse), 32'd0);
        send(B);
        for (int i = 0; i < LockN; i++) send(F);
        check_eq("t6_relock", 32'(locked), 32'd1);

        // Long fill run drives the 3-bit fill counter into saturation.
        for (int i = 0; i < 6; i++) send(F);
        check_eq("fill_sat_small", 32'(fill_count2), 32'd7);

        for (int n = 0; n < 3000; n++) begin
            bit v, c, r;
            logic [2:0] d;
            v = ($urandom_range(0, 99) < 85);
            c = ($urandom_range(0, 99) < 3);
            r = ($urandom_range(0, 199) == 0);
            d = ($urandom_range(0, 3) == 0) ? 3'($urandom) : pick[$urandom_range(0, 5)];
            step(v, d, c, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
